// File: rtl/disparo_tablero.sv
// Battleship-style board: a debounced-by-synchronizer button press either places a
// ship cell or fires a shot at (col, fila), reporting a 3-bit result code.
module disparo_tablero #(
    parameter int unsigned FILAS      = 8,
    parameter int unsigned COLS       = 8,
    parameter int unsigned MAX_BARCOS = 5
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [$clog2(COLS)-1:0]           col,
    input  logic [$clog2(FILAS)-1:0]          fila,
    input  logic                              modo,
    input  logic                              button_bomba,
    input  logic                              limpiar,
    output logic [COLS*FILAS-1:0]             matriz_barcos,
    output logic [COLS*FILAS-1:0]             matriz_disparos,
    output logic [2:0]                        resultado,
    output logic                              resultado_valido,
    output logic [$clog2(FILAS*COLS+1)-1:0]   num_barcos,
    output logic [$clog2(FILAS*COLS+1)-1:0]   num_aciertos,
    output logic                              fin_juego,
    output logic                              ocupado
);
    localparam int unsigned N  = FILAS * COLS;
    localparam int unsigned CW = $clog2(COLS);
    localparam int unsigned FW = $clog2(FILAS);
    localparam int unsigned NW = $clog2(N + 1);
    localparam int unsigned IW = $clog2(N);

    localparam logic [2:0] NADA        = 3'd0;
    localparam logic [2:0] COLOCADO    = 3'd1;
    localparam logic [2:0] OCUPADO     = 3'd2;
    localparam logic [2:0] ACIERTO     = 3'd3;
    localparam logic [2:0] FALLO       = 3'd4;
    localparam logic [2:0] REPETIDO    = 3'd5;
    localparam logic [2:0] FUERA_RANGO = 3'd6;
    localparam logic [2:0] LLENO       = 3'd7;

    typedef enum logic [1:0] {IDLE, EVAL, RESP, FIN} estado_t;

    estado_t          state, state_n;
    logic             sync1, sync2, sync3, primed, armado;
    logic             det_c, latch_c, in_rango_c, gana_c;
    logic [CW-1:0]    col_q;
    logic [FW-1:0]    fila_q;
    logic             modo_q;
    logic [IW-1:0]    idx_c;
    logic [N-1:0]     barcos_n, disparos_n;
    logic [NW-1:0]    nb_n, na_n;
    logic [2:0]       res_n;

    // Synchronizer plus arming: a press only counts once a released level has been
    // seen from the pin, so a button held through reset release issues nothing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1  <= 1'b1;
            sync2  <= 1'b1;
            sync3  <= 1'b1;
            primed <= 1'b0;
            armado <= 1'b0;
        end else begin
            sync1  <= button_bomba;
            sync2  <= sync1;
            sync3  <= sync2;
            primed <= 1'b1;
            armado <= armado | (primed & sync1);
        end
    end

    assign det_c      = armado & sync3 & ~sync2;
    assign in_rango_c = (32'(col_q) < COLS) && (32'(fila_q) < FILAS);
    assign idx_c      = IW'(col_q) * IW'(FILAS) + IW'(fila_q);
    assign gana_c     = (resultado == ACIERTO) && (num_aciertos == num_barcos) &&
                        (num_barcos != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            col_q            <= '0;
            fila_q           <= '0;
            modo_q           <= 1'b0;
            matriz_barcos    <= '0;
            matriz_disparos  <= '0;
            num_barcos       <= '0;
            num_aciertos     <= '0;
            resultado        <= NADA;
            resultado_valido <= 1'b0;
            fin_juego        <= 1'b0;
            ocupado          <= 1'b0;
        end else begin
            state            <= state_n;
            matriz_barcos    <= barcos_n;
            matriz_disparos  <= disparos_n;
            num_barcos       <= nb_n;
            num_aciertos     <= na_n;
            resultado        <= res_n;
            resultado_valido <= (state_n == RESP);
            fin_juego        <= (state_n == FIN);
            ocupado          <= (state_n != IDLE);
            if (latch_c) begin
                col_q  <= col;
                fila_q <= fila;
                modo_q <= modo;
            end
        end
    end

    // Next state and board/counter updates; out-of-range is tested before any cell read matters.
    always_comb begin
        state_n     = state;
        barcos_n    = matriz_barcos;
        disparos_n  = matriz_disparos;
        nb_n        = num_barcos;
        na_n        = num_aciertos;
        res_n       = resultado;
        latch_c     = 1'b0;
        case (state)
            IDLE: begin
                if (det_c) begin
                    latch_c = 1'b1;
                    state_n = EVAL;
                end
            end
            EVAL: begin
                state_n = RESP;
                if (!in_rango_c) begin
                    res_n = FUERA_RANGO;
                end else if (!modo_q) begin
                    if (matriz_barcos[idx_c]) begin
                        res_n = OCUPADO;
                    end else if (num_barcos == NW'(MAX_BARCOS)) begin
                        res_n = LLENO;
                    end else begin
                        barcos_n[idx_c] = 1'b1;
                        nb_n            = num_barcos + NW'(1);
                        res_n           = COLOCADO;
                    end
                end else if (matriz_disparos[idx_c]) begin
                    res_n = REPETIDO;
                end else begin
                    disparos_n[idx_c] = 1'b1;
                    if (matriz_barcos[idx_c]) begin
                        na_n  = num_aciertos + NW'(1);
                        res_n = ACIERTO;
                    end else begin
                        res_n = FALLO;
                    end
                end
            end
            RESP:    state_n = gana_c ? FIN : IDLE;
            FIN:     state_n = FIN;
            default: state_n = IDLE;
        endcase
        if (limpiar) begin
            state_n    = IDLE;
            barcos_n   = '0;
            disparos_n = '0;
            nb_n       = '0;
            na_n       = '0;
            res_n      = NADA;
            latch_c    = 1'b0;
        end
    end
endmodule

// File: tb/tb_disparo_tablero.sv
// Scoreboard bench: two instances (8x8/5 ships and 6x6/3 ships) share stimulus;
// a board-level reference model predicts each result pulse.
module tb_disparo_tablero;
    logic       clk, rst, modo, button_bomba, limpiar;
    logic [2:0] col, fila;

    logic [63:0] b0_barcos, b0_disparos;
    logic [2:0]  b0_res;
    logic        b0_vld, b0_fin, b0_ocup;
    logic [6:0]  b0_nb, b0_na;

    logic [35:0] b1_barcos, b1_disparos;
    logic [2:0]  b1_res;
    logic        b1_vld, b1_fin, b1_ocup;
    logic [5:0]  b1_nb, b1_na;

    disparo_tablero #(.FILAS(8), .COLS(8), .MAX_BARCOS(5)) dut0 (
        .clk(clk), .rst(rst), .col(col), .fila(fila), .modo(modo),
        .button_bomba(button_bomba), .limpiar(limpiar),
        .matriz_barcos(b0_barcos), .matriz_disparos(b0_disparos),
        .resultado(b0_res), .resultado_valido(b0_vld),
        .num_barcos(b0_nb), .num_aciertos(b0_na),
        .fin_juego(b0_fin), .ocupado(b0_ocup));

    disparo_tablero #(.FILAS(6), .COLS(6), .MAX_BARCOS(3)) dut1 (
        .clk(clk), .rst(rst), .col(col), .fila(fila), .modo(modo),
        .button_bomba(button_bomba), .limpiar(limpiar),
        .matriz_barcos(b1_barcos), .matriz_disparos(b1_disparos),
        .resultado(b1_res), .resultado_valido(b1_vld),
        .num_barcos(b1_nb), .num_aciertos(b1_na),
        .fin_juego(b1_fin), .ocupado(b1_ocup));

    typedef struct packed {
        logic [2:0]  r;
        int          nb;
        int          na;
        logic [63:0] sb;
        logic [63:0] sd;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int checks = 0;
    int errors = 0;

    int          p_filas [2] = '{8, 6};
    int          p_cols  [2] = '{8, 6};
    int          p_max   [2] = '{5, 3};
    logic [63:0] m_ship  [2];
    logic [63:0] m_shot  [2];
    int          m_nb    [2];
    int          m_na    [2];
    bit          m_fin   [2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, req);
        end
    endtask

    task automatic model_clear();
        for (int d = 0; d < 2; d++) begin
            m_ship[d] = '0;
            m_shot[d] = '0;
            m_nb[d]   = 0;
            m_na[d]   = 0;
            m_fin[d]  = 1'b0;
        end
    endtask

    // Game rules applied to the board arrays; returns whether a command is accepted.
    task automatic model_cmd(input int d, input int c, input int f, input int m,
                             output bit issued, output exp_t e);
        int idx;
        logic [2:0] r;
        issued = 1'b0;
        e      = '0;
        if (m_fin[d]) return;
        issued = 1'b1;
        if (c >= p_cols[d] || f >= p_filas[d]) begin
            r = 3'd6;
        end else begin
            idx = c * p_filas[d] + f;
            if (m == 0) begin
                if (m_ship[d][idx])           r = 3'd2;
                else if (m_nb[d] == p_max[d]) r = 3'd7;
                else begin
                    m_ship[d][idx] = 1'b1;
                    m_nb[d]++;
                    r = 3'd1;
                end
            end else if (m_shot[d][idx]) begin
                r = 3'd5;
            end else begin
                m_shot[d][idx] = 1'b1;
                if (m_ship[d][idx]) begin
                    m_na[d]++;
                    r = 3'd3;
                end else begin
                    r = 3'd4;
                end
            end
        end
        if (r == 3'd3 && m_na[d] == m_nb[d] && m_nb[d] > 0) m_fin[d] = 1'b1;
        e.r  = r;
        e.nb = m_nb[d];
        e.na = m_na[d];
        e.sb = m_ship[d];
        e.sd = m_shot[d];
    endtask

    task automatic cmp_pulse(input string tag, input exp_t e, input logic [2:0] r,
                             input int nb, input int na,
                             input logic [63:0] sb, input logic [63:0] sd);
        chk({tag, " resultado"},       64'(r),  64'(e.r));
        chk({tag, " num_barcos"},      64'(nb), 64'(e.nb));
        chk({tag, " num_aciertos"},    64'(na), 64'(e.na));
        chk({tag, " matriz_barcos"},   sb,      e.sb);
        chk({tag, " matriz_disparos"}, sd,      e.sd);
    endtask

    // Monitor: every result pulse is matched against the oldest prediction.
    always @(negedge clk) begin
        if (b0_vld) begin
            if (q0.size() == 0) chk("dut0 unexpected pulse", 64'd1, 64'd0);
            else cmp_pulse("dut0", q0.pop_front(), b0_res, int'(b0_nb), int'(b0_na),
                           b0_barcos, b0_disparos);
        end
        if (b1_vld) begin
            if (q1.size() == 0) chk("dut1 unexpected pulse", 64'd1, 64'd0);
            else cmp_pulse("dut1", q1.pop_front(), b1_res, int'(b1_nb), int'(b1_na),
                           64'(b1_barcos), 64'(b1_disparos));
        end
    end

    task automatic chk_cleared(input string tag);
        chk({tag, " dut0 barcos"},   b0_barcos,        64'd0);
        chk({tag, " dut0 disparos"}, b0_disparos,      64'd0);
        chk({tag, " dut0 counters"}, 64'({b0_nb, b0_na}), 64'd0);
        chk({tag, " dut0 flags"},    64'({b0_res, b0_vld, b0_fin, b0_ocup}), 64'd0);
        chk({tag, " dut1 barcos"},   64'(b1_barcos),   64'd0);
        chk({tag, " dut1 disparos"}, 64'(b1_disparos), 64'd0);
        chk({tag, " dut1 counters"}, 64'({b1_nb, b1_na}), 64'd0);
        chk({tag, " dut1 flags"},    64'({b1_res, b1_vld, b1_fin, b1_ocup}), 64'd0);
    endtask

    task automatic clear();
        @(posedge clk); #1 limpiar = 1'b1;
        @(posedge clk); #1 limpiar = 1'b0;
        model_clear();
        chk_cleared("limpiar");
    endtask

    // One press: pulse expected on the 5th falling clock edge after the button drops
    // (2 synchronizer flops, detect, EVAL, RESP).
    task automatic press(input int c, input int f, input int m);
        exp_t e;
        bit   iss [2];
        int   seen [2];
        int   at [2];
        for (int d = 0; d < 2; d++) begin
            model_cmd(d, c, f, m, iss[d], e);
            if (iss[d]) begin
                if (d == 0) q0.push_back(e);
                else        q1.push_back(e);
            end
            seen[d] = 0;
            at[d]   = -1;
        end
        @(posedge clk); #1;
        col = 3'(c); fila = 3'(f); modo = m[0];
        button_bomba = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (b0_vld) begin seen[0]++; at[0] = k; end
            if (b1_vld) begin seen[1]++; at[1] = k; end
        end
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("dut%0d pulse count (%0d,%0d,%0d)", d, c, f, m),
                64'(seen[d]), iss[d] ? 64'd1 : 64'd0);
            if (iss[d]) chk($sformatf("dut%0d latency", d), 64'(at[d]), 64'd5);
        end
        @(posedge clk); #1 button_bomba = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("dut0 fin_juego", 64'(b0_fin),  64'(m_fin[0]));
        chk("dut0 ocupado",   64'(b0_ocup), 64'(m_fin[0]));
        chk("dut1 fin_juego", 64'(b1_fin),  64'(m_fin[1]));
        chk("dut1 ocupado",   64'(b1_ocup), 64'(m_fin[1]));
    endtask

    initial begin
        int pulses;
        int c, f;
        rst = 1'b1; button_bomba = 1'b1; limpiar = 1'b0;
        col = '0; fila = '0; modo = 1'b0;
        model_clear();
        repeat (3) @(posedge clk);
        #1 chk_cleared("reset");
        rst = 1'b0;
        repeat (4) @(posedge clk);

        // Place, repeat placement, sink the only ship, then a discarded press.
        press(2, 5, 0);
        chk("dut0 bit21", 64'(b0_barcos[21]), 64'd1);
        press(2, 5, 0);
        press(2, 5, 1);
        press(3, 3, 0);

        // Fill the fleet, overflow, and a miss followed by a repeat shot.
        clear();
        press(0, 1, 0); press(1, 2, 0); press(2, 3, 0); press(3, 4, 0); press(4, 5, 0);
        press(5, 1, 0);
        press(0, 0, 1);
        press(0, 0, 1);
        // Out of range for the 6x6 instance only.
        press(0, 7, 0);
        press(7, 0, 1);
        press(6, 2, 1);

        // Clear in the same cycle the press is detected: command dropped.
        clear();
        press(1, 1, 0);
        @(posedge clk); #1 button_bomba = 1'b0;
        repeat (2) @(posedge clk);
        #1 limpiar = 1'b1;
        @(posedge clk); #1 limpiar = 1'b0;
        model_clear();
        pulses = 0;
        repeat (8) begin
            @(negedge clk);
            pulses += int'(b0_vld) + int'(b1_vld);
        end
        chk("clear-on-detect pulses", 64'(pulses), 64'd0);
        chk_cleared("clear-on-detect");
        @(posedge clk); #1 button_bomba = 1'b1;
        repeat (4) @(posedge clk);

        // Reset during EVAL with the button held low through release.
        press(3, 3, 0);
        @(posedge clk); #1 button_bomba = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk("dut0 busy in EVAL", 64'(b0_ocup), 64'd1);
        rst = 1'b1;
        #1 chk_cleared("async reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_clear();
        pulses = 0;
        repeat (12) begin
            @(negedge clk);
            pulses += int'(b0_vld) + int'(b1_vld) + int'(b0_ocup) + int'(b1_ocup);
        end
        chk("held-through-reset activity", 64'(pulses), 64'd0);
        @(posedge clk); #1 button_bomba = 1'b1;
        repeat (5) @(posedge clk);

        // Randomized play, biased toward a small corner so hits and repeats occur.
        for (int n = 0; n < 90; n++) begin
            if ($urandom_range(0, 19) == 0 || (m_fin[0] && m_fin[1])) begin
                clear();
            end else begin
                c = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 2));
                f = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 2));
                press(c, f, int'($urandom_range(0, 1)));
            end
        end

        repeat (5) @(posedge clk);
        chk("dut0 scoreboard drained", 64'(q0.size()), 64'd0);
        chk("dut1 scoreboard drained", 64'(q1.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/disparo_tablero.md
DISPARO_TABLERO -- requirements
Module: disparo_tablero

Interface
REQ-001 Parameter FILAS, default 8, row-index range per column word (bits per word), 2..16.
REQ-002 Parameter COLS, default 8, number of column words, 2..16.
REQ-003 Parameter MAX_BARCOS, default 5, max ship cells placeable, 1..FILAS*COLS.
REQ-004 Derived CW = clog2(COLS), FW = clog2(FILAS), NW = clog2(FILAS*COLS+1); not ports.
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 col  input  CW  column word index of the command.
REQ-008 fila  input  FW  bit index within the column word.
REQ-009 modo  input  1  0 = place ship cell, 1 = fire shot.
REQ-010 button_bomba  input  1  raw active-low button; a falling edge issues one command.
REQ-011 limpiar  input  1  synchronous clear of both boards and counters.
REQ-012 matriz_barcos  output  COLS*FILAS  ship board; bit col*FILAS+fila = cell [col][fila].
REQ-013 matriz_disparos  output  COLS*FILAS  shot board, same indexing.
REQ-014 resultado  output  3  result code of the last command.
REQ-015 resultado_valido  output  1  one-cycle pulse qualifying resultado.
REQ-016 num_barcos  output  NW  ship cells placed.
REQ-017 num_aciertos  output  NW  hits scored.
REQ-018 fin_juego  output  1  level, high in state FIN.
REQ-019 ocupado  output  1  high whenever state != IDLE.

Function
REQ-020 button_bomba SHALL pass through a 2-flop synchronizer; a command SHALL be detected in cycle E when the synchronized value goes 1 -> 0.
REQ-021 States IDLE, EVAL, RESP, FIN; encoding free.
REQ-022 IDLE: on detection at E, col/fila/modo SHALL be latched at E and state -> EVAL; detections in any other state SHALL be discarded.
REQ-023 EVAL (cycle E+1) SHALL update boards/counters per REQ-025..REQ-030 and -> RESP.
REQ-024 RESP (cycle E+2) SHALL drive resultado_valido = 1 with resultado stable; next state FIN if the win condition of REQ-031 holds, else IDLE.
REQ-025 Codes: 0 NADA, 1 COLOCADO, 2 OCUPADO, 3 ACIERTO, 4 FALLO, 5 REPETIDO, 6 FUERA_RANGO, 7 LLENO.
REQ-026 Latched col >= COLS or fila >= FILAS SHALL give FUERA_RANGO, no write, counters unchanged; checked before all other rules.
REQ-027 modo 0, cell of matriz_barcos = 1: OCUPADO, no write.
REQ-028 modo 0, cell = 0, num_barcos == MAX_BARCOS: LLENO, no write; otherwise set cell, num_barcos += 1, COLOCADO.
REQ-029 modo 1, cell of matriz_disparos = 1: REPETIDO, no change.
REQ-030 modo 1, shot cell 0: set shot cell; ship cell 1 -> ACIERTO, num_aciertos += 1; ship cell 0 -> FALLO.
REQ-031 Win: result ACIERTO and num_aciertos == num_barcos (post-update) and num_barcos > 0.
REQ-032 FIN: fin_juego = 1, boards and counters frozen, commands discarded; exit only by rst or limpiar.
REQ-033 limpiar = 1 SHALL, next edge, zero both boards and counters, resultado = 0, state -> IDLE, from any state; limpiar SHALL win over a detection or EVAL update in the same cycle (command dropped, no pulse).
REQ-034 resultado SHALL hold its value until the next RESP or clear.
REQ-035 Counters SHALL never exceed FILAS*COLS; no wrap.

Reset
REQ-036 rst high SHALL immediately force state IDLE, both boards 0, num_barcos 0, num_aciertos 0, resultado 0, resultado_valido 0, fin_juego 0, ocupado 0, synchronizer flops 1 (button released).
REQ-037 rst mid-command SHALL abort it; no resultado_valido pulse after release.
REQ-038 After rst release, a button held low SHALL NOT produce a command until released and pressed again.

Verification
REQ-039 Default params: modo 0, col 2, fila 5, press -> resultado_valido at E+2, resultado 1, bit 21 of matriz_barcos set, num_barcos 1.
REQ-040 Repeat same placement -> resultado 2, boards unchanged; fire at (2,5) -> 3, num_aciertos 1, fin_juego 1, ocupado 1; next press -> no pulse.
REQ-041 Place 5 distinct cells, sixth at new cell -> resultado 7, num_barcos 5; fire empty (0,0) twice -> 4 then 5.
REQ-042 col 0, fila 7 with FILAS = 6, COLS = 6 -> resultado 6, no board bit changes.
REQ-043 Assert limpiar in the same cycle a press is detected -> boards 0, counters 0, no pulse, state IDLE.
REQ-044 Assert rst during EVAL -> all outputs 0 asynchronously, no pulse after release; button held low through release -> no command.
